// File: rtl/ndp_unit.sv
// ndp_unit: output-stationary systolic GEMM engine, C = A*B, one A column
// and one B row per cycle, float (RNE, subnormals, inf/NaN) or wrap-around int.
// Ports:
//   clk, reset (sync, active-high)
//   in_a [ROWS*WIDTH], in_b [COLS*WIDTH], in_done_flag, SIMD_control [2]
//   out_c [ROWS*COLS*WIDTH], calc_done_flag
module ndp_unit #(
  parameter int WIDTH      = 16,
  parameter int IS_FLOAT   = 1,
  parameter int EXP_BITS   = 5,
  parameter int FRAC_BITS  = 10,
  parameter int ARR_HEIGHT = 4,
  parameter int ARR_WIDTH  = 4,
  parameter int SYS_HEIGHT = 1,
  parameter int SYS_WIDTH  = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic [SYS_HEIGHT*ARR_HEIGHT*WIDTH-1:0] in_a,
  input  logic [SYS_WIDTH*ARR_WIDTH*WIDTH-1:0]   in_b,
  input  logic in_done_flag,
  input  logic [1:0] SIMD_control,
  output logic [SYS_HEIGHT*ARR_HEIGHT*SYS_WIDTH*ARR_WIDTH*WIDTH-1:0] out_c,
  output logic calc_done_flag
);

  localparam int ROWS = SYS_HEIGHT*ARR_HEIGHT;
  localparam int COLS = SYS_WIDTH*ARR_WIDTH;
  localparam int LAT  = ROWS+COLS-1;
  localparam int CW   = $clog2(LAT+1);
  localparam int MW   = 2*FRAC_BITS+4;
  localparam int BIAS = (1 << (EXP_BITS-1)) - 1;
  localparam int EMAX = (1 << EXP_BITS) - 1;
  localparam int GW   = FRAC_BITS+4;
  localparam logic [WIDTH-1:0] QNAN =
    {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(FRAC_BITS-1){1'b0}}};

  function automatic int f_exp(input logic [EXP_BITS-1:0] e);
    return (e == '0) ? 1 : int'(e);
  endfunction

  // value = m * 2^q; rounds to nearest-even into the target format
  function automatic logic [WIDTH-1:0] f_pack(
    input logic s, input logic [MW-1:0] m, input int q);
    logic [MW+1:0] mx, rq, rem, half, one;
    int lead, sh, e;
    lead = -1;
    for (int i = 0; i < MW; i++)
      if (m[i]) lead = i;
    if (lead < 0) return {s, {(WIDTH-1){1'b0}}};
    // never drop fewer bits than the subnormal grid allows
    sh = lead - FRAC_BITS;
    if (sh < 1 - BIAS - FRAC_BITS - q)
      sh = 1 - BIAS - FRAC_BITS - q;
    mx  = {2'b00, m};
    one = {{(MW+1){1'b0}}, 1'b1};
    if (sh <= 0) begin
      rq = mx << (-sh);
    end else if (sh > MW) begin
      rq = '0;
    end else begin
      rq   = mx >> sh;
      rem  = mx & ((one << sh) - one);
      half = one << (sh - 1);
      if (rem > half || (rem == half && rq[0]))
        rq = rq + one;
    end
    e = q + sh + FRAC_BITS + BIAS;
    if (rq[FRAC_BITS+1]) begin
      rq = rq >> 1;
      e  = e + 1;
    end
    if (!rq[FRAC_BITS]) e = 0;
    if (e >= EMAX)
      return {s, {EXP_BITS{1'b1}}, {FRAC_BITS{1'b0}}};
    return {s, e[EXP_BITS-1:0], rq[FRAC_BITS-1:0]};
  endfunction

  function automatic logic [WIDTH-1:0] f_mul(
    input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [EXP_BITS-1:0] ea, eb;
    logic [FRAC_BITS-1:0] fa, fb;
    logic s, nan, inf_a, inf_b, zro_a, zro_b;
    logic [MW-1:0] p;
    int q;
    {ea, fa} = a[WIDTH-2:0];
    {eb, fb} = b[WIDTH-2:0];
    s     = a[WIDTH-1] ^ b[WIDTH-1];
    inf_a = (&ea) && fa == '0;
    inf_b = (&eb) && fb == '0;
    zro_a = ea == '0 && fa == '0;
    zro_b = eb == '0 && fb == '0;
    nan   = ((&ea) && fa != '0) || ((&eb) && fb != '0) ||
            (inf_a && zro_b) || (inf_b && zro_a);
    if (nan) return QNAN;
    if (inf_a || inf_b)
      return {s, {EXP_BITS{1'b1}}, {FRAC_BITS{1'b0}}};
    p = MW'({|ea, fa}) * MW'({|eb, fb});
    q = f_exp(ea) + f_exp(eb) - 2*BIAS - 2*FRAC_BITS;
    return f_pack(s, p, q);
  endfunction

  function automatic logic [WIDTH-1:0] f_add(
    input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] x, y;
    logic [GW-1:0] mx, my, mask, lone;
    logic [MW-1:0] m;
    logic inf_a, inf_b, stk, s;
    int ex, ey, d;
    inf_a = (&a[WIDTH-2:FRAC_BITS]) && a[FRAC_BITS-1:0] == '0;
    inf_b = (&b[WIDTH-2:FRAC_BITS]) && b[FRAC_BITS-1:0] == '0;
    if (((&a[WIDTH-2:FRAC_BITS]) && !inf_a) ||
        ((&b[WIDTH-2:FRAC_BITS]) && !inf_b) ||
        (inf_a && inf_b && a[WIDTH-1] != b[WIDTH-1]))
      return QNAN;
    if (inf_a) return a;
    if (inf_b) return b;
    // x is the larger magnitude; its sign wins unless the sum is zero
    if (b[WIDTH-2:0] > a[WIDTH-2:0]) begin
      x = b; y = a;
    end else begin
      x = a; y = b;
    end
    ex   = f_exp(x[WIDTH-2:FRAC_BITS]);
    ey   = f_exp(y[WIDTH-2:FRAC_BITS]);
    d    = ex - ey;
    lone = {{(GW-1){1'b0}}, 1'b1};
    mx   = {|x[WIDTH-2:FRAC_BITS], x[FRAC_BITS-1:0], 3'b000};
    my   = {|y[WIDTH-2:FRAC_BITS], y[FRAC_BITS-1:0], 3'b000};
    // guard/round/sticky alignment of the smaller operand
    if (d > GW-1) begin
      my = {{(GW-1){1'b0}}, |my};
    end else if (d > 0) begin
      mask = (lone << d) - lone;
      stk  = |(my & mask);
      my   = (my >> d) | {{(GW-1){1'b0}}, stk};
    end
    if (x[WIDTH-1] == y[WIDTH-1]) m = MW'(mx) + MW'(my);
    else                          m = MW'(mx) - MW'(my);
    s = (m == '0) ? (x[WIDTH-1] & y[WIDTH-1]) : x[WIDTH-1];
    return f_pack(s, m, ex - BIAS - FRAC_BITS - 3);
  endfunction

  function automatic logic [WIDTH-1:0] f_mac(
    input logic [WIDTH-1:0] acc,
    input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (IS_FLOAT != 0) return f_add(acc, f_mul(a, b));
    return acc + a * b;
  endfunction

  logic [CW-1:0] r_cnt;
  logic r_done;
  logic w_mode, w_valid;
  logic [WIDTH-1:0] w_ain  [ROWS];
  logic [WIDTH-1:0] w_bin  [COLS];
  logic [WIDTH-1:0] w_askw [ROWS];
  logic [WIDTH-1:0] w_bskw [COLS];
  logic [WIDTH-1:0] w_a_pe [ROWS][COLS];
  logic [WIDTH-1:0] w_b_pe [ROWS][COLS];

  // reserved modes all run the full-array GEMM
  assign w_mode  = |{SIMD_control, 1'b1};
  assign w_valid = !in_done_flag && !r_done && w_mode;
  assign calc_done_flag = r_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (in_done_flag) begin
      if (r_cnt != CW'(LAT)) r_cnt <= r_cnt + 1'b1;
      else                   r_done <= 1'b1;
    end else if (!r_done) begin
      r_cnt <= '0;
    end
  end

  for (genvar gr = 0; gr < ROWS; gr++) begin : g_askew
    assign w_ain[gr] = w_valid ? in_a[gr*WIDTH +: WIDTH] : '0;
    if (gr == 0) begin : g_direct
      assign w_askw[gr] = w_ain[gr];
    end else begin : g_line
      logic [WIDTH-1:0] r_line [gr];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < gr; i++) r_line[i] <= '0;
        end else begin
          r_line[0] <= w_ain[gr];
          for (int i = 1; i < gr; i++) r_line[i] <= r_line[i-1];
        end
      end
      assign w_askw[gr] = r_line[gr-1];
    end
  end

  for (genvar gc = 0; gc < COLS; gc++) begin : g_bskew
    assign w_bin[gc] = w_valid ? in_b[gc*WIDTH +: WIDTH] : '0;
    if (gc == 0) begin : g_direct
      assign w_bskw[gc] = w_bin[gc];
    end else begin : g_line
      logic [WIDTH-1:0] r_line [gc];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < gc; i++) r_line[i] <= '0;
        end else begin
          r_line[0] <= w_bin[gc];
          for (int i = 1; i < gc; i++) r_line[i] <= r_line[i-1];
        end
      end
      assign w_bskw[gc] = r_line[gc-1];
    end
  end

  for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
    for (genvar gc = 0; gc < COLS; gc++) begin : g_col
      logic [WIDTH-1:0] r_acc;
      // each PE owns the registers feeding it from its left/upper neighbour
      if (gc == 0) begin : g_a0
        assign w_a_pe[gr][gc] = w_askw[gr];
      end else begin : g_fa
        logic [WIDTH-1:0] r_fa;
        always_ff @(posedge clk) begin
          if (reset) r_fa <= '0;
          else       r_fa <= w_a_pe[gr][gc-1];
        end
        assign w_a_pe[gr][gc] = r_fa;
      end
      if (gr == 0) begin : g_b0
        assign w_b_pe[gr][gc] = w_bskw[gc];
      end else begin : g_fb
        logic [WIDTH-1:0] r_fb;
        always_ff @(posedge clk) begin
          if (reset) r_fb <= '0;
          else       r_fb <= w_b_pe[gr-1][gc];
        end
        assign w_b_pe[gr][gc] = r_fb;
      end
      always_ff @(posedge clk) begin
        if (reset)
          r_acc <= '0;
        else if (!r_done)
          r_acc <= f_mac(r_acc, w_a_pe[gr][gc], w_b_pe[gr][gc]);
      end
      assign out_c[(gr*COLS+gc)*WIDTH +: WIDTH] = r_acc;
    end
  end

endmodule

// File: tb/tb_ndp_unit.sv
// tb_ndp_unit: randomized self-checking bench for ndp_unit (fp16, 4x4).
// Reference model rounds exact real-valued results to fp16 with RNE.
module tb_ndp_unit;

  localparam int R    = 4;
  localparam int C    = 4;
  localparam int W    = 16;
  localparam int KMAX = 8;
  localparam int LAT  = R + C - 1;

  logic clk = 1'b0;
  logic reset;
  logic [R*W-1:0] in_a;
  logic [C*W-1:0] in_b;
  logic in_done_flag;
  logic [1:0] simd;
  logic [R*C*W-1:0] out_c;
  logic calc_done_flag;

  int checks = 0;
  int failures = 0;

  logic [15:0] ga [R][KMAX];
  logic [15:0] gb [KMAX][C];
  logic [15:0] gexp [R][C];
  int gk;

  ndp_unit dut (
    .clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b),
    .in_done_flag(in_done_flag), .SIMD_control(simd),
    .out_c(out_c), .calc_done_flag(calc_done_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic real pow2(input int n);
    real v = 1.0;
    for (int i = 0; i < n; i++) v = v * 2.0;
    for (int i = 0; i < -n; i++) v = v / 2.0;
    return v;
  endfunction

  function automatic real f2r(input logic [15:0] h);
    int e = int'(h[14:10]);
    int f = int'(h[9:0]);
    real v;
    if (e == 0) v = f * pow2(-24);
    else        v = (1024 + f) * pow2(e - 25);
    return h[15] ? -v : v;
  endfunction

  function automatic logic [14:0] rne_mag(input real ax);
    int e, n;
    real u;
    if (ax >= 65520.0) return 15'h7C00;
    if (ax < pow2(-14)) begin
      u = ax / pow2(-24);
      n = $rtoi(u);
      if (u - n > 0.5 || (u - n == 0.5 && (n % 2) == 1)) n++;
      return 15'(n);
    end
    e = -14;
    while (ax >= pow2(e + 1)) e++;
    u = ax / pow2(e - 10);
    n = $rtoi(u);
    if (u - n > 0.5 || (u - n == 0.5 && (n % 2) == 1)) n++;
    if (n == 2048) begin
      n = 1024;
      e++;
    end
    if (e + 15 >= 31) return 15'h7C00;
    return 15'(((e + 15) << 10) + (n - 1024));
  endfunction

  function automatic bit is_nan(input logic [15:0] h);
    return h[14:10] == 5'h1F && h[9:0] != 0;
  endfunction

  function automatic bit is_inf(input logic [15:0] h);
    return h[14:0] == 15'h7C00;
  endfunction

  function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b);
    logic s = a[15] ^ b[15];
    real x;
    if (is_nan(a) || is_nan(b)) return 16'h7E00;
    if ((is_inf(a) && b[14:0] == 0) || (is_inf(b) && a[14:0] == 0))
      return 16'h7E00;
    if (is_inf(a) || is_inf(b)) return {s, 15'h7C00};
    x = f2r(a) * f2r(b);
    if (x == 0.0) return {s, 15'h0};
    return {s, rne_mag(x < 0.0 ? -x : x)};
  endfunction

  function automatic logic [15:0] m_add(input logic [15:0] a, input logic [15:0] b);
    real x;
    if (is_nan(a) || is_nan(b)) return 16'h7E00;
    if (is_inf(a) && is_inf(b) && a[15] != b[15]) return 16'h7E00;
    if (is_inf(a)) return a;
    if (is_inf(b)) return b;
    x = f2r(a) + f2r(b);
    if (x == 0.0) return (a[15] & b[15]) ? 16'h8000 : 16'h0000;
    return {x < 0.0, rne_mag(x < 0.0 ? -x : x)};
  endfunction

  function automatic void build_model();
    logic [15:0] acc;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        acc = 16'h0000;
        for (int k = 0; k < gk; k++)
          acc = m_add(acc, m_mul(ga[r][k], gb[k][c]));
        gexp[r][c] = acc;
      end
  endfunction

  function automatic logic [15:0] rnd_fp();
    int sel = $urandom_range(0, 9);
    logic [15:0] v = 16'($urandom);
    case (sel)
      0: ;
      1: v[14:0] = 15'h0;
      2: v[14:10] = 5'h0;
      3: v[14:10] = 5'($urandom_range(1, 8));
      default: v[14:10] = 5'($urandom_range(8, 22));
    endcase
    return v;
  endfunction

  function automatic logic [15:0] rnd_norm();
    logic [15:0] v = 16'($urandom);
    v[14:10] = 5'($urandom_range(10, 20));
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    in_done_flag = 1'b0;
    in_a = '0;
    in_b = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive_beat(input int k);
    for (int r = 0; r < R; r++) in_a[r*W +: W] = ga[r][k];
    for (int c = 0; c < C; c++) in_b[c*W +: W] = gb[k][c];
    in_done_flag = 1'b0;
    @(negedge clk);
  endtask

  task automatic stream(input int from, input int to);
    for (int k = from; k < to; k++) drive_beat(k);
  endtask

  // lat = posedges after the first done posedge until the flag is seen
  task automatic run_drain(output int lat);
    in_done_flag = 1'b1;
    in_a = {$urandom, $urandom};
    in_b = {$urandom, $urandom};
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (calc_done_flag) begin
        lat = n - 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_done_flag = 1'b1;
    in_a = '1;
    in_b = '1;
    repeat (10) @(negedge clk);
    checks++;
    if (calc_done_flag !== 1'b0) begin
      failures++;
      $display("FAIL reset_flag got=%b exp=0", calc_done_flag);
    end
    checks++;
    if (out_c !== '0) begin
      failures++;
      $display("FAIL reset_outc got=%h exp=0", out_c);
    end
    do_reset();
  endtask

  task automatic test_ones();
    int lat;
    do_reset();
    gk = 5;
    for (int k = 0; k < gk; k++) begin
      for (int r = 0; r < R; r++) ga[r][k] = 16'h3C00;
      for (int c = 0; c < C; c++) gb[k][c] = 16'h3C00;
    end
    stream(0, gk);
    run_drain(lat);
    checks++;
    if (lat !== LAT) begin
      failures++;
      $display("FAIL ones_latency got=%0d exp=%0d", lat, LAT);
    end
    for (int i = 0; i < R*C; i++) begin
      checks++;
      if (out_c[i*W +: W] !== 16'h4500) begin
        failures++;
        $display("FAIL ones_c%0d got=%h exp=4500", i, out_c[i*W +: W]);
      end
    end
  endtask

  task automatic test_identity();
    int lat;
    do_reset();
    gk = 5;
    for (int k = 0; k < gk; k++) begin
      for (int r = 0; r < R; r++) ga[r][k] = (r == k) ? 16'h3C00 : 16'h0000;
      for (int c = 0; c < C; c++) begin
        gb[k][c] = 16'($urandom);
        gb[k][c][14:10] = 5'($urandom_range(1, 30));
      end
    end
    stream(0, gk);
    run_drain(lat);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        checks++;
        if (out_c[(r*C+c)*W +: W] !== gb[r][c]) begin
          failures++;
          $display("FAIL ident_c%0d%0d got=%h exp=%h", r, c,
                   out_c[(r*C+c)*W +: W], gb[r][c]);
        end
      end
  endtask

  task automatic test_random();
    int lat;
    for (int run = 0; run < 100; run++) begin
      do_reset();
      simd = 2'($urandom_range(0, 3));
      gk = 5;
      for (int k = 0; k < gk; k++) begin
        for (int r = 0; r < R; r++) ga[r][k] = rnd_fp();
        for (int c = 0; c < C; c++) gb[k][c] = rnd_fp();
      end
      build_model();
      stream(0, gk);
      run_drain(lat);
      checks++;
      if (lat !== LAT) begin
        failures++;
        $display("FAIL rand%0d_latency got=%0d exp=%0d", run, lat, LAT);
      end
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) begin
          checks++;
          if (out_c[(r*C+c)*W +: W] !== gexp[r][c]) begin
            failures++;
            $display("FAIL rand%0d_c%0d%0d got=%h exp=%h", run, r, c,
                     out_c[(r*C+c)*W +: W], gexp[r][c]);
          end
        end
    end
    simd = 2'b00;
  endtask

  task automatic test_reset_mid();
    int lat;
    do_reset();
    gk = 4;
    for (int k = 0; k < gk; k++) begin
      for (int r = 0; r < R; r++) ga[r][k] = rnd_norm();
      for (int c = 0; c < C; c++) gb[k][c] = rnd_norm();
    end
    stream(0, 3);
    in_a = {$urandom, $urandom};
    in_b = {$urandom, $urandom};
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < gk; k++) begin
      for (int r = 0; r < R; r++) ga[r][k] = rnd_norm();
      for (int c = 0; c < C; c++) gb[k][c] = rnd_norm();
    end
    build_model();
    for (int k = 0; k < gk; k++) begin
      drive_beat(k);
      checks++;
      if (calc_done_flag !== 1'b0) begin
        failures++;
        $display("FAIL rmid_flag_beat%0d got=%b exp=0", k, calc_done_flag);
      end
    end
    run_drain(lat);
    checks++;
    if (lat !== LAT) begin
      failures++;
      $display("FAIL rmid_latency got=%0d exp=%0d", lat, LAT);
    end
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        checks++;
        if (out_c[(r*C+c)*W +: W] !== gexp[r][c]) begin
          failures++;
          $display("FAIL rmid_c%0d%0d got=%h exp=%h", r, c,
                   out_c[(r*C+c)*W +: W], gexp[r][c]);
        end
      end
  endtask

  task automatic test_inf_nan();
    int lat;
    do_reset();
    gk = 4;
    for (int k = 0; k < gk; k++) begin
      for (int r = 0; r < R; r++) ga[r][k] = rnd_norm();
      for (int c = 0; c < C; c++) gb[k][c] = rnd_norm();
    end
    ga[1][2] = 16'h7C00;
    gb[2][3] = 16'h0000;
    build_model();
    stream(0, gk);
    run_drain(lat);
    checks++;
    if (out_c[(1*C+3)*W +: W] !== 16'h7E00) begin
      failures++;
      $display("FAIL infnan_c13 got=%h exp=7e00", out_c[(1*C+3)*W +: W]);
    end
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        checks++;
        if (out_c[(r*C+c)*W +: W] !== gexp[r][c]) begin
          failures++;
          $display("FAIL infnan_c%0d%0d got=%h exp=%h", r, c,
                   out_c[(r*C+c)*W +: W], gexp[r][c]);
        end
      end
  endtask

  task automatic test_abort();
    int lat;
    do_reset();
    gk = 5;
    for (int k = 0; k < gk; k++) begin
      for (int r = 0; r < R; r++) ga[r][k] = rnd_norm();
      for (int c = 0; c < C; c++) gb[k][c] = rnd_norm();
    end
    build_model();
    stream(0, 3);
    in_done_flag = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (calc_done_flag !== 1'b0) begin
        failures++;
        $display("FAIL abort_flag%0d got=%b exp=0", i, calc_done_flag);
      end
    end
    stream(3, gk);
    run_drain(lat);
    checks++;
    if (lat !== LAT) begin
      failures++;
      $display("FAIL abort_latency got=%0d exp=%0d", lat, LAT);
    end
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        checks++;
        if (out_c[(r*C+c)*W +: W] !== gexp[r][c]) begin
          failures++;
          $display("FAIL abort_c%0d%0d got=%h exp=%h", r, c,
                   out_c[(r*C+c)*W +: W], gexp[r][c]);
        end
      end
  endtask

  task automatic test_k0();
    int lat;
    do_reset();
    run_drain(lat);
    checks++;
    if (lat !== LAT) begin
      failures++;
      $display("FAIL k0_latency got=%0d exp=%0d", lat, LAT);
    end
    checks++;
    if (out_c !== '0) begin
      failures++;
      $display("FAIL k0_outc got=%h exp=0", out_c);
    end
  endtask

  task automatic test_hold();
    int lat;
    logic [R*C*W-1:0] expv;
    do_reset();
    gk = 5;
    for (int k = 0; k < gk; k++) begin
      for (int r = 0; r < R; r++) ga[r][k] = rnd_norm();
      for (int c = 0; c < C; c++) gb[k][c] = rnd_norm();
    end
    build_model();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) expv[(r*C+c)*W +: W] = gexp[r][c];
    stream(0, gk);
    run_drain(lat);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (calc_done_flag !== 1'b1 || out_c !== expv) begin
        failures++;
        $display("FAIL hold%0d flag=%b out=%h exp_out=%h", i,
                 calc_done_flag, out_c, expv);
      end
    end
    for (int i = 0; i < 3; i++) drive_beat(i);
    checks++;
    if (calc_done_flag !== 1'b1 || out_c !== expv) begin
      failures++;
      $display("FAIL hold_after_beats flag=%b out=%h exp_out=%h",
               calc_done_flag, out_c, expv);
    end
    in_done_flag = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (calc_done_flag !== 1'b0 || out_c !== '0) begin
      failures++;
      $display("FAIL hold_reset flag=%b out=%h exp=0", calc_done_flag, out_c);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_done_flag = 1'b0;
    in_a = '0;
    in_b = '0;
    simd = 2'b00;
    gk = 0;
    test_reset();
    test_ones();
    test_identity();
    test_random();
    test_reset_mid();
    test_inf_nan();
    test_abort();
    test_k0();
    test_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
